// File: rtl/my_ram_pkg.sv
// Shared constants and state encoding for the 512-word RAM and its block-copy engine.
package my_ram_pkg;

  localparam int unsigned RAM_ADDR_W = 9;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } copier_state_t;

endpackage

// File: rtl/my_ram_512.sv
// 512-word single-port RAM: synchronous write on rising clk, combinational read on addr.
module my_ram_512
  import my_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // Write port: store the input word when load is high.
  always_ff @(posedge clk) begin
    if (load) begin
      mem[addr] <= in;
    end
  end

  // Read port: asynchronous read of the addressed word.
  always_comb begin
    out = mem[addr];
  end

endmodule

// File: rtl/my_ram_copier.sv
// Block-copy engine: copies len words from src to dst inside the RAM, one read
// cycle plus one write cycle per word, and accumulates a 16-bit sum of the data.
module my_ram_copier
  import my_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] ram_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  copier_state_t     state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] data_q;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_next_addr;
  logic [DATA_W-1:0] sum_next;

  // Address adders and counters; truncation to ADDR_W bits gives the modulo-512 wrap.
  always_comb begin
    len_clamped  = (len > MAX_LEN) ? MAX_LEN : len;
    cnt_next     = cnt + ONE;
    wr_addr      = dst_q + cnt[ADDR_W-1:0];
    rd_next_addr = src_q + cnt_next[ADDR_W-1:0];
    sum_next     = sum + data_q;
  end

  // Copy FSM; RAM controls are registered one cycle ahead so they decode the
  // state being entered, keeping start/src/dst/len off any combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      cnt      <= '0;
      data_q   <= '0;
      sum      <= '0;
      ram_addr <= '0;
      ram_in   <= '0;
      ram_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len_clamped;
            cnt   <= '0;
            sum   <= '0;
            if (len_clamped != '0) begin
              state    <= READ;
              busy     <= 1'b1;
              ram_addr <= src;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          data_q   <= ram_out;
          state    <= WRITE;
          ram_addr <= wr_addr;
          ram_in   <= ram_out;
          ram_load <= 1'b1;
        end
        WRITE: begin
          sum      <= sum_next;
          cnt      <= cnt_next;
          ram_in   <= '0;
          ram_load <= 1'b0;
          if (cnt_next == len_q) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            ram_addr <= '0;
          end else begin
            state    <= READ;
            ram_addr <= rd_next_addr;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          ram_load <= 1'b0;
          ram_addr <= '0;
          ram_in   <= '0;
        end
      endcase
    end
  end

endmodule
